// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, combinational instruction memory
// interface and a 2-entry {pc, instr} FIFO feeding decode. Redirects flush the
// FIFO and reload the PC. A misaligned redirect target raises a one-cycle
// error. A head PC beyond the memory size raises a range error.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 128
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        misalign_err,
   output logic        range_err,
   output logic [31:0] fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_fifo_pc    [0:1];
   logic [31:0] r_fifo_instr [0:1];
   logic        r_head;
   logic        r_tail;
   logic [1:0]  r_count;
   logic [31:0] r_fetch_count;
   logic        r_misalign;

   logic        w_fire;
   logic        w_enq;
   logic [31:0] w_word_idx;

   // A fire frees the head slot in the same cycle, so a full FIFO can still
   // accept the word being fetched. A redirect suppresses the enqueue.
   assign w_fire     = out_valid && out_ready;
   assign w_enq      = !redirect_valid && ((r_count != 2'd2) || w_fire);

   assign imem_addr    = r_pc;
   assign out_valid    = (r_count != 2'd0);
   assign out_pc       = r_fifo_pc[r_head];
   assign out_instr    = r_fifo_instr[r_head];
   assign misalign_err = r_misalign;
   assign fetch_count  = r_fetch_count;

   assign w_word_idx = {2'b00, out_pc[31:2]};
   assign range_err  = out_valid && (w_word_idx >= IMEM_WORDS);

   // PC, FIFO pointers and occupancy; redirect flushes and reloads the PC.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else if (redirect_valid) begin
         r_pc    <= {redirect_pc[31:2], 2'b00};
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_fire) begin
            r_head <= ~r_head;
         end
         if (w_enq) begin
            r_tail <= ~r_tail;
            r_pc   <= r_pc + 32'd4;
         end
         case ({w_enq, w_fire})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage: write the fetched word into the tail slot.
   // NOTE: the storage array is deliberately not reset; out_valid (driven by
   // the reset occupancy count) guarantees stale contents are never presented.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_fifo_pc[r_tail]    <= r_pc;
         r_fifo_instr[r_tail] <= imem_rdata;
      end
   end

   // Saturating handshake counter; a fire coinciding with a redirect counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= 32'd0;
      end else if (w_fire && (r_fetch_count != 32'hFFFF_FFFF)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   // One-cycle pulse after taking a redirect to a non-word-aligned target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

endmodule
